step_counter: RTL and testbench

//   Parametrised up/down step counter with synchronous load/clear, run-time selectable

---
 rtl/step_counter.sv | 141 ++++++++++++++
 tb/tb_step_counter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/step_counter.sv
// -----------------------------------------------------------------------------
// step_counter
//   Up/down step counter with synchronous clear/load, run-time selectable
//   wrap or saturate arithmetic, zero/max decode and a sticky overflow flag.
//
//   Optional feature macro: STEP_COUNTER_TERM_EN
//     defined     : tc pulses for one cycle after an update lands on term
//     not defined : tc is tied to 0 and term is ignored
//
// Parameters
//   WIDTH  counter width (>=2)
//   STEP2  increment applied by en2 (1..2**WIDTH-1)
//   DSTEP  decrement applied by en_d (1..2**WIDTH-1)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous reset, active low
//   clr       synchronous clear to 0 (also clears ovf)
//   load      synchronous load of init (also clears ovf)
//   init      load value
//   en1       count += 1
//   en2       count += STEP2
//   en_d      count -= DSTEP
//   sat_mode  0: modulo wrap, 1: clamp at 0 / all-ones
//   term      terminal value for tc
//   count     current count register
//   zero      count == 0
//   max       count == all-ones
//   ovf       sticky over/underflow flag
//   tc        one-cycle terminal pulse
// -----------------------------------------------------------------------------
module step_counter #(
  parameter int WIDTH = 4,
  parameter int STEP2 = 2,
  parameter int DSTEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] init,
  input  logic             en1,
  input  logic             en2,
  input  logic             en_d,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             max,
  output logic             ovf,
  output logic             tc
);

  localparam logic [WIDTH:0] ONE_W   = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] STEP2_W = (WIDTH+1)'(STEP2);
  localparam logic [WIDTH:0] DSTEP_W = (WIDTH+1)'(DSTEP);

  logic [WIDTH-1:0] count_reg, count_next;
  logic             ovf_reg, ovf_next;
  logic             update;

  // Both datapaths are evaluated every cycle; the priority chain below picks one.
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           carry;
  logic           borrow;

  assign sum    = {1'b0, count_reg} + (en1 ? ONE_W : STEP2_W);
  assign diff   = {1'b0, count_reg} - DSTEP_W;
  assign carry  = sum[WIDTH];
  assign borrow = ({1'b0, count_reg} < DSTEP_W);

  always_comb begin
    count_next = count_reg;
    ovf_next   = ovf_reg;
    update     = 1'b0;
    if (clr) begin
      count_next = '0;
      ovf_next   = 1'b0;
      update     = 1'b1;
    end else if (load) begin
      count_next = init;
      ovf_next   = 1'b0;
      update     = 1'b1;
    end else if (en1 || en2) begin
      update = 1'b1;
      if (carry) begin
        ovf_next   = 1'b1;
        count_next = sat_mode ? '1 : sum[WIDTH-1:0];
      end else begin
        count_next = sum[WIDTH-1:0];
      end
    end else if (en_d) begin
      update = 1'b1;
      if (borrow) begin
        ovf_next   = 1'b1;
        count_next = sat_mode ? '0 : diff[WIDTH-1:0];
      end else begin
        count_next = diff[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign count = count_reg;
  assign ovf   = ovf_reg;
  assign zero  = (count_reg == '0);
  assign max   = (count_reg == '1);

`ifdef STEP_COUNTER_TERM_EN
  logic tc_reg;

  // The "changed" qualifier keeps tc from re-firing while count sits on term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_reg <= 1'b0;
    end else begin
      tc_reg <= update && (count_next == term) && (count_next != count_reg);
    end
  end

  assign tc = tc_reg;
`else
  logic unused_term;
  logic unused_update;

  assign unused_term   = ^term;
  assign unused_update = update;
  assign tc            = 1'b0;
`endif

endmodule

// File: tb/tb_step_counter.sv
module tb_step_counter;

`ifdef STEP_COUNTER_TERM_EN
  localparam bit TERM_EN = 1'b1;
`else
  localparam bit TERM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, load, en1, en2, en_d, sat_mode;
  logic [3:0] init, term;
  logic [3:0] count;
  logic       zero, max, ovf, tc;

  int checks   = 0;
  int failures = 0;

  step_counter #(.WIDTH(4), .STEP2(2), .DSTEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .init(init),
    .en1(en1), .en2(en2), .en_d(en_d), .sat_mode(sat_mode), .term(term),
    .count(count), .zero(zero), .max(max), .ovf(ovf), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] c, input logic z,
                         input logic m, input logic o, input logic t);
    chk({tag, ".count"}, {28'd0, count}, {28'd0, c});
    chk({tag, ".zero"},  {31'd0, zero},  {31'd0, z});
    chk({tag, ".max"},   {31'd0, max},   {31'd0, m});
    chk({tag, ".ovf"},   {31'd0, ovf},   {31'd0, o});
    chk({tag, ".tc"},    {31'd0, tc},    {31'd0, t});
    $display("step %s: count=%0h zero=%0b max=%0b ovf=%0b tc=%0b", tag, count, zero, max, ovf, tc);
  endtask

  // Apply one cycle of requests, then return #1 after the edge with inputs idle.
  task automatic op(input logic c, input logic l, input logic [3:0] i,
                    input logic e1, input logic e2, input logic ed);
    clr = c; load = l; init = i; en1 = e1; en2 = e2; en_d = ed;
    @(posedge clk);
    #1;
    clr = 1'b0; load = 1'b0; en1 = 1'b0; en2 = 1'b0; en_d = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 0; load = 0; init = 0; en1 = 0; en2 = 0; en_d = 0;
    sat_mode = 0; term = 4'h5;
    #3;
    chk_all("reset", 4'h0, 1, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // async reset mid-count, no clock edge in between
    op(0, 1, 4'h7, 0, 0, 0);
    chk_all("load7", 4'h7, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 4'h0, 1, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // wrap overflow
    sat_mode = 0;
    op(0, 1, 4'hE, 0, 0, 0);
    chk_all("wrap_loadE", 4'hE, 0, 0, 0, 0);
    op(0, 0, 4'h0, 0, 1, 0);
    chk_all("wrap_en2", 4'h0, 1, 0, 1, 0);
    op(0, 0, 4'h0, 1, 0, 0);
    chk_all("wrap_en1_sticky", 4'h1, 0, 0, 1, 0);

    // saturating overflow and exact landing
    sat_mode = 1;
    op(0, 1, 4'hE, 0, 0, 0);
    chk_all("sat_loadE", 4'hE, 0, 0, 0, 0);
    op(0, 0, 4'h0, 0, 1, 0);
    chk_all("sat_en2", 4'hF, 0, 1, 1, 0);
    op(0, 0, 4'h0, 1, 0, 0);
    chk_all("sat_en1_hold", 4'hF, 0, 1, 1, 0);
    op(0, 1, 4'hD, 0, 0, 0);
    op(0, 0, 4'h0, 0, 1, 0);
    chk_all("sat_exact_max", 4'hF, 0, 1, 0, 0);
    op(0, 1, 4'h1, 0, 0, 0);
    op(0, 0, 4'h0, 0, 0, 1);
    chk_all("sat_exact_zero", 4'h0, 1, 0, 0, 0);

    // underflow
    sat_mode = 0;
    op(1, 0, 4'h0, 0, 0, 0);
    chk_all("clr", 4'h0, 1, 0, 0, 0);
    op(0, 0, 4'h0, 0, 0, 1);
    chk_all("wrap_under", 4'hF, 0, 1, 1, 0);
    op(1, 0, 4'h0, 0, 0, 0);
    chk_all("clr_ovf", 4'h0, 1, 0, 0, 0);
    sat_mode = 1;
    op(0, 0, 4'h0, 0, 0, 1);
    chk_all("sat_under", 4'h0, 1, 0, 1, 0);

    // priority
    sat_mode = 0;
    op(0, 1, 4'h3, 0, 0, 0);
    op(0, 0, 4'h0, 1, 1, 1);
    chk_all("prio_en1", 4'h4, 0, 0, 0, 0);
    op(0, 0, 4'h0, 0, 1, 1);
    chk_all("prio_en2", 4'h6, 0, 0, 0, 0);
    op(0, 1, 4'h9, 1, 0, 0);
    chk_all("prio_load", 4'h9, 0, 0, 0, 0);
    op(0, 0, 4'h0, 0, 0, 0);
    chk_all("hold", 4'h9, 0, 0, 0, 0);
    op(0, 1, 4'hF, 0, 0, 0);
    op(0, 0, 4'h0, 1, 0, 0);
    chk_all("ovf_before_clr", 4'h0, 1, 0, 1, 0);
    op(1, 1, 4'h9, 0, 0, 0);
    chk_all("prio_clr", 4'h0, 1, 0, 0, 0);

    // terminal count pulse
    term = 4'h5;
    op(0, 1, 4'h3, 0, 0, 0);
    chk_all("tc_load3", 4'h3, 0, 0, 0, 0);
    op(0, 0, 4'h0, 1, 0, 0);
    chk_all("tc_en1_4", 4'h4, 0, 0, 0, 0);
    op(0, 0, 4'h0, 1, 0, 0);
    chk_all("tc_en1_5", 4'h5, 0, 0, 0, TERM_EN);
    op(0, 0, 4'h0, 0, 0, 0);
    chk_all("tc_hold", 4'h5, 0, 0, 0, 0);
    op(0, 1, 4'h5, 0, 0, 0);
    chk_all("tc_reload_same", 4'h5, 0, 0, 0, 0);
    op(0, 0, 4'h0, 0, 0, 1);
    op(0, 1, 4'h5, 0, 0, 0);
    chk_all("tc_load_term", 4'h5, 0, 0, 0, TERM_EN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
